snes_controller_reader: RTL and testbench



---
 rtl/snes_pkg.sv | 29 ++
 rtl/snes_controller_reader_sync.sv | 22 ++
 rtl/snes_controller_reader.sv | 109 ++++++++++
 tb/tb_snes_controller_reader.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/snes_pkg.sv
// Shared types and constants for the SNES pad reader: frame FSM states and button bit positions.
// Button indices match the order the pad shifts them out, first bit first.
package snes_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        LOW,
        HIGH,
        DONE
    } state_t;

    localparam int NUM_BUTTONS = 12;
    localparam int FRAME_BITS  = 16;

    localparam int BTN_B      = 0;
    localparam int BTN_Y      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;
    localparam int BTN_A      = 8;
    localparam int BTN_X      = 9;
    localparam int BTN_L      = 10;
    localparam int BTN_R      = 11;

endpackage

// File: rtl/snes_controller_reader_sync.sv
// Two-flop synchronizer for one asynchronous bit; 2-cycle latency, no backpressure.
// Resets to 1 so an undriven (pulled-up) pad line reads as "not pressed" from the start.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/snes_controller_reader.sv
// Polls a serial SNES pad each poll period; frame takes 34*CLK_DIV+1 cycles, valid/fault pulse one cycle after DONE.
// No backpressure: buttons is a level output refreshed only by good frames.
module snes_controller_reader
    import snes_pkg::*;
#(
    parameter int CLK_DIV     = 60,
    parameter int POLL_PERIOD = 166_667
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   pad_data,
    output logic                   pad_latch,
    output logic                   pad_clk,
    output logic [0:NUM_BUTTONS-1] buttons,
    output logic                   valid,
    output logic                   fault
);

    localparam int PH_W  = $clog2(2 * CLK_DIV);
    localparam int PC_W  = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
    localparam int IDX_W = $clog2(FRAME_BITS);

    localparam logic [PH_W-1:0]  PH_T_LAST     = PH_W'(CLK_DIV - 1);
    localparam logic [PH_W-1:0]  PH_LATCH_LAST = PH_W'(2 * CLK_DIV - 1);
    localparam logic [PC_W-1:0]  POLL_LAST     = PC_W'(POLL_PERIOD - 1);
    localparam logic [IDX_W-1:0] IDX_LAST      = IDX_W'(FRAME_BITS - 1);

    state_t                  state;
    state_t                  state_next;
    logic [PH_W-1:0]         phase;
    logic [PC_W-1:0]         poll_cnt;
    logic [IDX_W-1:0]        idx;
    logic [0:FRAME_BITS-1]   shift;
    logic                    data_sync;
    logic                    frame_good;

    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d   (pad_data),
        .q   (data_sync)
    );

    // Bits past the 12 real buttons are always released on a genuine pad.
    assign frame_good = &shift[NUM_BUTTONS:FRAME_BITS-1];

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (poll_cnt == POLL_LAST)     state_next = LATCH;
            LATCH: if (phase == PH_LATCH_LAST)    state_next = LOW;
            LOW:   if (phase == PH_T_LAST)        state_next = HIGH;
            HIGH:  if (phase == PH_T_LAST)        state_next = (idx == IDX_LAST) ? DONE : LOW;
            DONE:                                 state_next = IDLE;
            default:                              state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            phase     <= '0;
            poll_cnt  <= '0;
            idx       <= '0;
            shift     <= '1;
            pad_latch <= 1'b0;
            pad_clk   <= 1'b1;
            buttons   <= '0;
            valid     <= 1'b0;
            fault     <= 1'b0;
        end else begin
            state <= state_next;

            if (state == IDLE || state_next != state) begin
                phase <= '0;
            end else begin
                phase <= phase + PH_W'(1);
            end

            if (state == IDLE && poll_cnt != POLL_LAST) begin
                poll_cnt <= poll_cnt + PC_W'(1);
            end else begin
                poll_cnt <= '0;
            end

            if (state == LATCH) begin
                idx <= '0;
            end else if (state == HIGH && state_next == LOW) begin
                idx <= idx + IDX_W'(1);
            end

            // Sample at the end of the low phase, when the bit has been stable longest.
            if (state == LOW && phase == PH_T_LAST) begin
                shift[idx] <= data_sync;
            end

            // Pad lines are registered from the next state so they align with the FSM.
            pad_latch <= (state_next == LATCH);
            pad_clk   <= (state_next != LOW);

            valid <= (state == DONE) && frame_good;
            fault <= (state == DONE) && !frame_good;
            if (state == DONE && frame_good) begin
                buttons <= ~shift[0:NUM_BUTTONS-1];
            end
        end
    end

endmodule

// File: tb/tb_snes_controller_reader.sv
// Directed bench for snes_controller_reader with a shift-register pad model and an expected-frame scoreboard.
module tb_snes_controller_reader;

    localparam int CLK_DIV     = 4;
    localparam int POLL_PERIOD = 20;
    localparam int FRAME_LEN   = 34 * CLK_DIV + 1;
    localparam int FRAME_GAP   = POLL_PERIOD + FRAME_LEN;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pad_data;
    logic        pad_latch;
    logic        pad_clk;
    logic [0:11] buttons;
    logic        valid;
    logic        fault;

    always #5 clk = ~clk;

    snes_controller_reader #(
        .CLK_DIV     (CLK_DIV),
        .POLL_PERIOD (POLL_PERIOD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .pad_data  (pad_data),
        .pad_latch (pad_latch),
        .pad_clk   (pad_clk),
        .buttons   (buttons),
        .valid     (valid),
        .fault     (fault)
    );

    // Pad: parallel load on latch rise, shift toward bit 0 on clock rise, ones shifted in.
    logic [15:0] pad_word = 16'hFFFF;
    logic [15:0] pad_reg  = 16'hFFFF;
    always @(posedge pad_latch or posedge pad_clk) begin
        if (pad_latch === 1'b1) pad_reg <= pad_word;
        else                    pad_reg <= {1'b1, pad_reg[15:1]};
    end
    assign pad_data = pad_reg[0];

    typedef struct {
        logic        good;
        logic [0:11] btn;
    } exp_t;
    exp_t sb[$];

    int passed = 0;
    int total  = 0;
    int cyc    = 0;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    endtask

    task automatic wait_latch(output int n, output int rise_cyc);
        n = 0;
        while (pad_latch !== 1'b1 && n < 1000) begin
            tick();
            n++;
        end
        rise_cyc = cyc;
    endtask

    // Entered on the first cycle pad_latch is high; follows the frame to its valid/fault pulse.
    task automatic wait_result(input string tag);
        int          n       = 0;
        int          latch_w = 1;
        int          pulses  = 0;
        int          bad_low = 0;
        int          bad_hi  = 0;
        int          run     = 1;
        int          moves   = 0;
        logic        prev    = pad_clk;
        logic [0:11] b0      = buttons;
        exp_t        e;
        while (!(valid || fault) && n < 400) begin
            tick();
            n++;
            if (pad_latch === 1'b1) latch_w++;
            if (!(valid || fault) && buttons !== b0) moves++;
            if (pad_clk !== prev) begin
                if (prev === 1'b0 && run != CLK_DIV) bad_low++;
                if (prev === 1'b1 && pulses > 0 && run != CLK_DIV) bad_hi++;
                if (pad_clk === 1'b0) pulses++;
                run = 1;
            end else begin
                run++;
            end
            prev = pad_clk;
        end
        chk({tag, "_latency"}, n, FRAME_LEN);
        chk({tag, "_latch_width"}, latch_w, 2 * CLK_DIV);
        chk({tag, "_clk_pulses"}, pulses, 16);
        chk({tag, "_clk_low_width"}, bad_low, 0);
        chk({tag, "_clk_high_gap"}, bad_hi, 0);
        chk({tag, "_buttons_stable"}, moves, 0);
        chk({tag, "_sb_nonempty"}, (sb.size() > 0), 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, "_valid"}, valid, e.good);
            chk({tag, "_fault"}, fault, !e.good);
            chk({tag, "_buttons"}, buttons, e.btn);
        end
        tick();
        chk({tag, "_pulse_end"}, {valid, fault}, 2'b00);
    endtask

    initial begin
        int   n;
        int   rise;
        int   prev_rise;
        exp_t e;

        rst = 1'b1;
        repeat (3) tick();
        chk("rst_latch", pad_latch, 1'b0);
        chk("rst_clk", pad_clk, 1'b1);
        chk("rst_buttons", buttons, 12'h000);
        chk("rst_valid", valid, 1'b0);
        chk("rst_fault", fault, 1'b0);
        rst = 1'b0;

        // 1: idle pad
        pad_word = 16'hFFFF;
        e.good = 1'b1; e.btn = 12'b0000_0000_0000; sb.push_back(e);
        wait_latch(n, rise);
        chk("first_latch_delay", n, POLL_PERIOD);
        wait_result("idle");
        prev_rise = rise;

        // 2/3: B and Start pressed, full waveform checked inside wait_result
        pad_word = 16'hFFF6;
        e.good = 1'b1; e.btn = 12'b1001_0000_0000; sb.push_back(e);
        wait_latch(n, rise);
        chk("b_start_period", rise - prev_rise, FRAME_GAP);
        wait_result("b_start");
        prev_rise = rise;

        // 4: unused bit 13 low with A pressed is rejected
        pad_word = 16'hDEFF;
        e.good = 1'b0; e.btn = 12'b1001_0000_0000; sb.push_back(e);
        wait_latch(n, rise);
        chk("bad_period", rise - prev_rise, FRAME_GAP);
        wait_result("bad_frame");
        prev_rise = rise;

        // 5: reset in the LOW phase of bit 7
        pad_word = 16'hFFFF;
        wait_latch(n, rise);
        chk("abort_period", rise - prev_rise, FRAME_GAP);
        repeat (8 + 8 * 7 + 1) tick();
        chk("abort_in_low", pad_clk, 1'b0);
        rst = 1'b1;
        tick();
        chk("abort_clk", pad_clk, 1'b1);
        chk("abort_latch", pad_latch, 1'b0);
        chk("abort_buttons", buttons, 12'h000);
        chk("abort_valid", valid, 1'b0);
        rst = 1'b0;

        // 6: every button pressed, then all released
        pad_word = 16'hF000;
        e.good = 1'b1; e.btn = 12'hFFF; sb.push_back(e);
        wait_latch(n, rise);
        chk("post_reset_latch_delay", n, POLL_PERIOD);
        wait_result("all_pressed");
        prev_rise = rise;

        pad_word = 16'hFFFF;
        e.good = 1'b1; e.btn = 12'h000; sb.push_back(e);
        wait_latch(n, rise);
        chk("released_period", rise - prev_rise, FRAME_GAP);
        wait_result("all_released");

        chk("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
